// File: rtl/sva_verdict_collector.sv
// sva_verdict_collector: outcome counters, sticky verdict and timestamped
// event FIFO for a single-attempt SVA evaluation FSM.
//
// Ports:
//   sys_clk, sys_rst          clock and synchronous active-high reset
//   gclk_tick                 one pulse per user-clock rising edge
//   busy, succ, lazy_succ,    evaluation FSM status and outcome pulses
//   fail, clear               soft clear (keeps the period counter)
//   succ_cnt, lazy_cnt,       saturating outcome counters
//   fail_cnt, verdict         0 NONE, 1 PASS, 2 LAZY, 3 FAIL
//   first_fail_valid/period   sticky first-fail timestamp
//   frame_done                one-cycle pulse after a busy falling edge
//   evt_valid/kind/period     show-ahead event FIFO head (kind 1 = fail)
//   evt_ready                 consumer pop strobe
//   evt_overflow, drop_cnt    dropped-event tracking
module sva_verdict_collector #(
    parameter int CNT_WIDTH    = 16,
    parameter int PERIOD_WIDTH = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic                    gclk_tick,
    input  logic                    busy,
    input  logic                    succ,
    input  logic                    lazy_succ,
    input  logic                    fail,
    input  logic                    clear,
    output logic [CNT_WIDTH-1:0]    succ_cnt,
    output logic [CNT_WIDTH-1:0]    lazy_cnt,
    output logic [CNT_WIDTH-1:0]    fail_cnt,
    output logic [1:0]              verdict,
    output logic                    first_fail_valid,
    output logic [PERIOD_WIDTH-1:0] first_fail_period,
    output logic                    frame_done,
    output logic                    evt_valid,
    output logic                    evt_kind,
    output logic [PERIOD_WIDTH-1:0] evt_period,
    input  logic                    evt_ready,
    output logic                    evt_overflow,
    output logic [CNT_WIDTH-1:0]    drop_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        V_NONE = 2'd0,
        V_PASS = 2'd1,
        V_LAZY = 2'd2,
        V_FAIL = 2'd3
    } verdict_e;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(
        input logic [CNT_WIDTH-1:0] v,
        input logic                 en
    );
        return (en && (v != '1)) ? v + CNT_WIDTH'(1) : v;
    endfunction

    verdict_e                verdict_q, verdict_d;
    logic [PERIOD_WIDTH-1:0] period_q, period_d;
    logic [CNT_WIDTH-1:0]    succ_cnt_q, succ_cnt_d;
    logic [CNT_WIDTH-1:0]    lazy_cnt_q, lazy_cnt_d;
    logic [CNT_WIDTH-1:0]    fail_cnt_q, fail_cnt_d;
    logic [CNT_WIDTH-1:0]    drop_cnt_q, drop_cnt_d;
    logic                    overflow_q, overflow_d;
    logic                    ff_valid_q, ff_valid_d;
    logic [PERIOD_WIDTH-1:0] ff_period_q, ff_period_d;
    logic                    busy_q, busy_d;
    logic                    busy_prev_q, busy_prev_d;
    logic                    frame_done_q, frame_done_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]          count_q, count_d;
    logic [PERIOD_WIDTH:0]   mem_q [FIFO_DEPTH];
    logic [PERIOD_WIDTH:0]   mem_d [FIFO_DEPTH];
    logic [PERIOD_WIDTH:0]   head;

    logic pop, push_req, full, push_en, drop;

    // Verdict: fail dominates and is absorbing; lazy dominates pass.
    always_comb begin
        verdict_d = verdict_q;
        unique case (verdict_q)
            V_NONE: begin
                if (fail)           verdict_d = V_FAIL;
                else if (lazy_succ) verdict_d = V_LAZY;
                else if (succ)      verdict_d = V_PASS;
            end
            V_PASS: begin
                if (fail)           verdict_d = V_FAIL;
                else if (lazy_succ) verdict_d = V_LAZY;
            end
            V_LAZY: begin
                if (fail)           verdict_d = V_FAIL;
            end
            V_FAIL: verdict_d = V_FAIL;
        endcase
        if (clear) verdict_d = V_NONE;
    end

    always_comb begin
        period_d     = period_q + PERIOD_WIDTH'(gclk_tick);
        succ_cnt_d   = sat_inc(succ_cnt_q, succ);
        lazy_cnt_d   = sat_inc(lazy_cnt_q, lazy_succ);
        fail_cnt_d   = sat_inc(fail_cnt_q, fail);
        ff_valid_d   = ff_valid_q;
        ff_period_d  = ff_period_q;
        busy_d       = busy;
        busy_prev_d  = busy_q;
        frame_done_d = busy_prev_q & ~busy_q;
        mem_d        = mem_q;

        pop      = evt_valid && evt_ready;
        push_req = fail | lazy_succ;
        full     = (count_q == FULL_CNT);
        // A pop in the same cycle frees the slot, so a full FIFO still
        // accepts the push.
        push_en  = push_req && (!full || pop);
        drop     = push_req && full && !pop;

        drop_cnt_d = sat_inc(drop_cnt_q, drop);
        overflow_d = overflow_q | drop;

        if (fail && !ff_valid_q) begin
            ff_valid_d  = 1'b1;
            ff_period_d = period_q;
        end

        if (push_en) mem_d[wr_ptr_q] = {fail, period_q};
        wr_ptr_d = wr_ptr_q + PTR_W'(push_en);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + (PTR_W + 1)'(push_en) - (PTR_W + 1)'(pop);

        if (clear) begin
            succ_cnt_d   = '0;
            lazy_cnt_d   = '0;
            fail_cnt_d   = '0;
            drop_cnt_d   = '0;
            overflow_d   = 1'b0;
            ff_valid_d   = 1'b0;
            ff_period_d  = '0;
            busy_d       = 1'b0;
            busy_prev_d  = 1'b0;
            frame_done_d = 1'b0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            verdict_q    <= V_NONE;
            period_q     <= '0;
            succ_cnt_q   <= '0;
            lazy_cnt_q   <= '0;
            fail_cnt_q   <= '0;
            drop_cnt_q   <= '0;
            overflow_q   <= 1'b0;
            ff_valid_q   <= 1'b0;
            ff_period_q  <= '0;
            busy_q       <= 1'b0;
            busy_prev_q  <= 1'b0;
            frame_done_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            verdict_q    <= verdict_d;
            period_q     <= period_d;
            succ_cnt_q   <= succ_cnt_d;
            lazy_cnt_q   <= lazy_cnt_d;
            fail_cnt_q   <= fail_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            overflow_q   <= overflow_d;
            ff_valid_q   <= ff_valid_d;
            ff_period_q  <= ff_period_d;
            busy_q       <= busy_d;
            busy_prev_q  <= busy_prev_d;
            frame_done_q <= frame_done_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge sys_clk) begin
        mem_q <= mem_d;
    end

    assign head              = mem_q[rd_ptr_q];
    assign succ_cnt          = succ_cnt_q;
    assign lazy_cnt          = lazy_cnt_q;
    assign fail_cnt          = fail_cnt_q;
    assign verdict           = verdict_q;
    assign first_fail_valid  = ff_valid_q;
    assign first_fail_period = ff_period_q;
    assign frame_done        = frame_done_q;
    assign evt_valid         = (count_q != '0);
    assign evt_kind          = head[PERIOD_WIDTH];
    assign evt_period        = head[PERIOD_WIDTH-1:0];
    assign evt_overflow      = overflow_q;
    assign drop_cnt          = drop_cnt_q;

endmodule

// File: tb/tb_sva_verdict_collector.sv
// Testbench for sva_verdict_collector: directed scenarios plus random
// traffic, scored against a behavioural model and an event queue.
module tb_sva_verdict_collector;

    localparam int CW    = 4;
    localparam int PW    = 4;
    localparam int DEPTH = 8;
    localparam int CMAX  = (1 << CW) - 1;
    localparam int PMOD  = 1 << PW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic sys_rst = 1'b0, gclk_tick = 1'b0, busy = 1'b0;
    logic succ = 1'b0, lazy_succ = 1'b0, fail = 1'b0, clear = 1'b0;
    logic evt_ready = 1'b0;
    logic [CW-1:0] succ_cnt, lazy_cnt, fail_cnt, drop_cnt;
    logic [1:0]    verdict;
    logic          first_fail_valid, frame_done, evt_valid, evt_kind;
    logic          evt_overflow;
    logic [PW-1:0] first_fail_period, evt_period;

    sva_verdict_collector #(
        .CNT_WIDTH(CW), .PERIOD_WIDTH(PW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .sys_clk(clk), .sys_rst(sys_rst), .gclk_tick(gclk_tick),
        .busy(busy), .succ(succ), .lazy_succ(lazy_succ), .fail(fail),
        .clear(clear), .succ_cnt(succ_cnt), .lazy_cnt(lazy_cnt),
        .fail_cnt(fail_cnt), .verdict(verdict),
        .first_fail_valid(first_fail_valid),
        .first_fail_period(first_fail_period), .frame_done(frame_done),
        .evt_valid(evt_valid), .evt_kind(evt_kind),
        .evt_period(evt_period), .evt_ready(evt_ready),
        .evt_overflow(evt_overflow), .drop_cnt(drop_cnt)
    );

    typedef struct packed {
        logic          kind;
        logic [PW-1:0] period;
    } ev_t;

    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;
    ev_t exp_q[$];

    int m_period, m_succ, m_lazy, m_fail, m_drop, m_ffp;
    bit m_ovf, m_ffv, m_fd, m_b1, m_b2;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic int m_verdict();
        if (m_fail > 0) return 3;
        if (m_lazy > 0) return 2;
        if (m_succ > 0) return 1;
        return 0;
    endfunction

    task automatic m_zero();
        m_succ = 0; m_lazy = 0; m_fail = 0; m_drop = 0;
        m_ovf = 0; m_ffv = 0; m_ffp = 0;
        m_fd = 0; m_b1 = 0; m_b2 = 0;
        exp_q.delete();
    endtask

    // Reference model: state as seen after each sampling edge.
    always @(posedge clk) begin : model
        int  ts;
        ev_t e;
        ts = m_period;
        if (sys_rst) begin
            m_zero();
            m_period = 0;
        end else begin
            if (clear) begin
                m_zero();
            end else begin
                if (succ && m_succ < CMAX) m_succ++;
                if (lazy_succ && m_lazy < CMAX) m_lazy++;
                if (fail && m_fail < CMAX) m_fail++;
                if (fail && !m_ffv) begin
                    m_ffv = 1;
                    m_ffp = ts;
                end
                if (fail || lazy_succ) begin
                    if (exp_q.size() < DEPTH) begin
                        e.kind   = fail;
                        e.period = ts[PW-1:0];
                        exp_q.push_back(e);
                    end else begin
                        if (m_drop < CMAX) m_drop++;
                        m_ovf = 1;
                    end
                end
                m_fd = m_b2 && !m_b1;
                m_b2 = m_b1;
                m_b1 = busy;
            end
            if (gclk_tick) m_period = (m_period + 1) % PMOD;
        end
    end

    // Monitor: compares outputs mid-cycle and scores each FIFO pop.
    always @(negedge clk) begin : monitor
        ev_t e;
        if (mon_en) begin
            check("succ_cnt", succ_cnt, m_succ);
            check("lazy_cnt", lazy_cnt, m_lazy);
            check("fail_cnt", fail_cnt, m_fail);
            check("verdict", verdict, m_verdict());
            check("ff_valid", first_fail_valid, m_ffv);
            check("ff_period", first_fail_period, m_ffp);
            check("frame_done", frame_done, m_fd);
            check("drop_cnt", drop_cnt, m_drop);
            check("overflow", evt_overflow, m_ovf);
            check("evt_valid", evt_valid, exp_q.size() != 0);
            if (evt_valid && evt_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_empty: got valid 1 expected 0");
                end else begin
                    e = exp_q.pop_front();
                    check("evt_kind", evt_kind, e.kind);
                    check("evt_period", evt_period, e.period);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        succ = 0; lazy_succ = 0; fail = 0;
        gclk_tick = 0; clear = 0; sys_rst = 0;
    endtask

    task automatic do_reset();
        sys_rst = 1;
        step();
    endtask

    initial begin
        do_reset();
        mon_en = 1'b1;

        // Reset, succ counting
        repeat (3) begin succ = 1; step(); end
        check("t1_succ", succ_cnt, 3);
        check("t1_verdict", verdict, 1);
        check("t1_valid", evt_valid, 0);
        check("t1_ffv", first_fail_valid, 0);

        // Fail timestamp and stickiness
        repeat (5) begin gclk_tick = 1; step(); end
        fail = 1; step();
        check("t2_fail", fail_cnt, 1);
        check("t2_verdict", verdict, 3);
        check("t2_ffp", first_fail_period, 5);
        check("t2_kind", evt_kind, 1);
        check("t2_period", evt_period, 5);
        succ = 1; step();
        check("t2_sticky", verdict, 3);
        repeat (2) begin gclk_tick = 1; step(); end
        fail = 1; step();
        check("t2_ffp2", first_fail_period, 5);
        evt_ready = 1;
        repeat (3) step();
        evt_ready = 0;
        check("t2_drain", evt_valid, 0);

        // Simultaneous pulses
        do_reset();
        repeat (2) begin gclk_tick = 1; step(); end
        fail = 1; lazy_succ = 1; succ = 1; step();
        check("t3_succ", succ_cnt, 1);
        check("t3_lazy", lazy_cnt, 1);
        check("t3_fail", fail_cnt, 1);
        check("t3_verdict", verdict, 3);
        check("t3_kind", evt_kind, 1);
        check("t3_period", evt_period, 2);
        evt_ready = 1; step(); evt_ready = 0;
        check("t3_one", evt_valid, 0);

        // FIFO overflow
        do_reset();
        repeat (10) begin lazy_succ = 1; step(); end
        check("t4_drop", drop_cnt, 2);
        check("t4_ovf", evt_overflow, 1);
        evt_ready = 1; lazy_succ = 1; step(); evt_ready = 0;
        check("t4_nodrop", drop_cnt, 2);
        evt_ready = 1;
        repeat (9) step();
        evt_ready = 0;
        check("t4_drain", evt_valid, 0);

        // Saturation, wrap, clear
        do_reset();
        repeat (20) begin succ = 1; step(); end
        check("t5_sat", succ_cnt, 15);
        repeat (17) begin gclk_tick = 1; step(); end
        fail = 1; step();
        check("t5_wrap", first_fail_period, 1);
        check("t5_head", evt_period, 1);
        clear = 1; gclk_tick = 1; step();
        check("t5_clr_succ", succ_cnt, 0);
        check("t5_clr_fail", fail_cnt, 0);
        check("t5_clr_verd", verdict, 0);
        check("t5_clr_valid", evt_valid, 0);
        check("t5_clr_ffv", first_fail_valid, 0);
        lazy_succ = 1; step();
        check("t5_kind", evt_kind, 0);
        check("t5_period", evt_period, 2);

        // Frame done and mid-run reset
        do_reset();
        busy = 1;
        repeat (4) step();
        busy = 0; step();
        check("t6_fd0", frame_done, 0);
        step();
        check("t6_fd1", frame_done, 1);
        step();
        check("t6_fd2", frame_done, 0);
        repeat (4) begin lazy_succ = 1; step(); end
        check("t6_half", evt_valid, 1);
        sys_rst = 1; fail = 1; step();
        check("t6_fail", fail_cnt, 0);
        check("t6_lazy", lazy_cnt, 0);
        check("t6_valid", evt_valid, 0);
        check("t6_verdict", verdict, 0);
        check("t6_ffv", first_fail_valid, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            succ      = ($urandom % 5 == 0);
            lazy_succ = ($urandom % 5 == 0);
            fail      = ($urandom % 10 == 0);
            gclk_tick = ($urandom % 3 == 0);
            if ($urandom % 6 == 0) busy = ~busy;
            evt_ready = (i < 1500) ? ($urandom % 4 == 0)
                                   : ($urandom % 4 != 0);
            clear     = ($urandom % 60 == 0);
            sys_rst   = ($urandom % 700 == 0);
            step();
        end
        busy = 0;
        evt_ready = 1;
        repeat (12) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sva_verdict_collector.md
# sva_verdict_collector

Downstream consumer of a single-attempt SVA evaluation FSM block. Sits on `sys_clk` and receives the FSM's `succ`, `lazy_succ` and `fail` outcome pulses together with its `busy` flag. It keeps saturating outcome counters and a sticky verdict state machine. It timestamps every fail and lazy-success event with the user-clock period in which it occurred, and buffers these in a show-ahead event FIFO read by the testbench or host.

## Interface

**Parameters**
- `CNT_WIDTH`, 16: width of each outcome counter and the drop counter.
- `PERIOD_WIDTH`, 16: width of the user-clock period timestamp.
- `FIFO_DEPTH`, 8: event FIFO entries; must be a power of two and at least 2.

**Ports**
- `sys_clk` in 1: system clock. The single clock of the block.
- `sys_rst` in 1: reset, synchronous and active-high.
- `gclk_tick` in 1: one-`sys_clk` pulse per user-clock rising edge, from the gclk edge detector.
- `busy` in 1: the evaluation FSM is computing.
- `succ` in 1: pulse, attempt finished successfully.
- `lazy_succ` in 1: pulse, attempt reached the lazy-success state.
- `fail` in 1: pulse, attempt failed.
- `clear` in 1: synchronous soft clear pulse.
- `succ_cnt` out CNT_WIDTH: saturating count of `succ`.
- `lazy_cnt` out CNT_WIDTH: saturating count of `lazy_succ`.
- `fail_cnt` out CNT_WIDTH: saturating count of `fail`.
- `verdict` out 2: 0 NONE, 1 PASS, 2 LAZY, 3 FAIL.
- `first_fail_valid` out 1: sticky; a fail has been seen.
- `first_fail_period` out PERIOD_WIDTH: timestamp of the first fail.
- `frame_done` out 1: one-cycle pulse on a `busy` falling edge.
- `evt_valid` out 1: FIFO head valid.
- `evt_kind` out 1: head kind; 1 = fail, 0 = lazy.
- `evt_period` out PERIOD_WIDTH: head timestamp.
- `evt_ready` in 1: consumer pops the head when `evt_valid && evt_ready`.
- `evt_overflow` out 1: sticky; at least one event was dropped.
- `drop_cnt` out CNT_WIDTH: saturating count of dropped events.

## Operation

**Reset and clear**
- Reset (`sys_rst` high at a `sys_clk` edge) zeroes all outputs and counters, empties the FIFO, sets `verdict` to NONE and zeroes the period counter.
- `clear` does the same, except it does not touch the period counter. `sys_rst` has priority over `clear`.

**Period counter**
- Increments on `gclk_tick` and wraps modulo 2^PERIOD_WIDTH.
- An event's timestamp is the counter value in the same cycle as the event pulse, i.e. before that cycle's increment.

**Counters**
- Each outcome pulse increments its own counter by 1.
- Counters saturate at all-ones and never wrap.
- Simultaneous pulses in one cycle are each counted.

**Verdict FSM** (fail is sticky)
- NONE: `fail` → FAIL; else `lazy_succ` → LAZY; else `succ` → PASS.
- PASS: `fail` → FAIL; `lazy_succ` → LAZY.
- LAZY: `fail` → FAIL; `succ` keeps LAZY.
- FAIL: absorbing; left only on reset or clear.

**First fail**
- On the first `fail` while `first_fail_valid` is 0, capture the period into `first_fail_period` and set `first_fail_valid`.
- Later fails do not update either output.

**Event FIFO**
- A cycle with `fail` pushes {kind 1, period}.
- Otherwise, a cycle with `lazy_succ` pushes {kind 0, period}.
- At most one push per cycle. `succ` never pushes.
- When the FIFO is full and no pop occurs that cycle, the push is dropped: `drop_cnt` increments and `evt_overflow` sets.
- Push and pop in the same cycle while full: both take effect; nothing is dropped and occupancy is unchanged.
- Empty with simultaneous push: the entry becomes visible the next cycle. There is no fall-through in the same cycle.
- Read and write pointers wrap modulo FIFO_DEPTH.

**Frame done**
- `busy` is registered once internally.
- `frame_done` = previous `busy` && current `busy` low, then registered, giving a one-cycle pulse.

## Timing

- Every output is registered.
- Pulse at edge N → counters, `verdict`, `first_fail_*`, `drop_cnt` and `evt_overflow` update at edge N+1.
- FIFO: push at edge N → `evt_valid` high after edge N+1 (if the FIFO was empty). Pop at edge N → the next head, or `evt_valid` low, after edge N+1.
- `busy` falls between edges N-1 and N → `frame_done` high for exactly the cycle after edge N+1.
- Reset asserted mid-operation takes effect at the next edge regardless of FIFO or FSM state. Pushes and outcome pulses in that cycle are discarded.
- `evt_kind` and `evt_period` are don't-care while `evt_valid` is 0. The bench checks them only when valid.

## Test plan

1. **Reset, succ counting.** Reset, then 3 `succ` pulses with no ticks → `succ_cnt`=3, `verdict`=1, `evt_valid`=0, `first_fail_valid`=0.
2. **Fail timestamp and stickiness.** 5 `gclk_tick`s, then `fail` → `fail_cnt`=1, `verdict`=3, `first_fail_period`=5, FIFO head {1,5}. A later `succ` leaves `verdict`=3. A second `fail` at period 7 leaves `first_fail_period`=5.
3. **Simultaneous pulses.** Same cycle `fail`+`lazy_succ`+`succ` at period 2 → each counter +1, exactly one FIFO entry {1,2}, `verdict`=3.
4. **FIFO overflow.** `evt_ready`=0, FIFO_DEPTH=8, 10 `lazy_succ` pulses → 8 entries held, `drop_cnt`=2, `evt_overflow`=1. Then a push and pop in one cycle while full → no drop, `drop_cnt` stays 2.
5. **Saturation, wrap, clear.** CNT_WIDTH=4 with 20 `succ` → `succ_cnt`=15. PERIOD_WIDTH=4 with 17 ticks then `fail` → timestamp 1. `clear` → all counters 0, `verdict`=0, FIFO empty, next event still stamped with the unreset period.
6. **Frame done and mid-run reset.** `busy` high 4 cycles then low → single `frame_done` pulse 2 edges later. Reset asserted with FIFO half-full and `fail` asserted in the same cycle → all outputs 0 at the next edge and `fail_cnt`=0.
